// File: rtl/equalizer_pkg.sv
// Shared types and widths for the equalizer input AXIS interface.
package equalizer_pkg;

  localparam int AXIS_DATA_W = 128;
  localparam int AXIS_ID_W   = 8;
  localparam int AXIS_USER_W = 8;
  localparam int SAMP_W      = 32;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_ID_W-1:0]   tid;
    logic [AXIS_USER_W-1:0] tuser;
    logic                   tlast;
  } eq_axis_beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } pkr_state_e;

endpackage

// File: rtl/axis_lane_packer.sv
// Accept-driven lane packer: collects LANES samples into one word, lane 0 earliest.
module axis_lane_packer #(
  parameter int SAMP_W = 32,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      accept,
  input  logic [SAMP_W-1:0]         data,
  output logic [LANES*SAMP_W-1:0]   word,
  output logic                      full
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANE_W-1:0]        lane;
  logic [LANES*SAMP_W-1:0]  shreg;

  // New samples enter the top lane and shift down, so the earliest lands in lane 0.
  assign word = {data, shreg[LANES*SAMP_W-1:SAMP_W]};
  assign full = accept && (lane == LANE_W'(LANES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lane  <= '0;
      shreg <= '0;
    end else if (accept) begin
      shreg <= word;
      lane  <= full ? '0 : lane + 1'b1;
    end
  end

endmodule

// File: rtl/equalizer_in_axis_packer.sv
// Equalizer input AXIS transmitter: packs I/Q samples into beats, tags symbols and frames.
module equalizer_in_axis_packer #(
  parameter int SAMP_W    = 32,
  parameter int LANES     = 4,
  parameter int SYM_BEATS = 64,
  parameter int ID_W      = 8,
  parameter int USER_W    = 8
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_areset,
  input  logic [ID_W-1:0]          cfg_tid,
  input  logic [USER_W-1:0]        cfg_nsym,
  input  logic                     start,
  input  logic                     abort,
  input  logic [SAMP_W-1:0]        s_samp_tdata,
  input  logic                     s_samp_tvalid,
  output logic                     s_samp_tready,
  output logic [LANES*SAMP_W-1:0]  m_axis_tdata,
  output logic [ID_W-1:0]          m_axis_tid,
  output logic [USER_W-1:0]        m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  output logic                     busy,
  output logic                     frame_done
);

  import equalizer_pkg::*;

  localparam int BEAT_W = (SYM_BEATS > 1) ? $clog2(SYM_BEATS) : 1;

  pkr_state_e               state, state_nxt;
  logic [ID_W-1:0]          tid_q;
  logic [USER_W-1:0]        nsym_q;
  logic [USER_W-1:0]        sym;
  logic [BEAT_W-1:0]        beat;
  logic [LANES*SAMP_W-1:0]  word;
  logic                     accept, start_ok, abort_pk, full, fire;
  logic                     last_beat, last_sym, frame_end;
  eq_axis_beat_t            out_q;
  logic                     tvalid_q, done_q;

  assign s_samp_tready = (state == PACK);
  assign busy          = (state != IDLE);
  assign accept        = s_samp_tvalid && s_samp_tready;
  assign start_ok      = (state == IDLE) && start && !abort && (cfg_nsym != '0);
  assign abort_pk      = (state == PACK) && abort;
  // Abort wins over a completing 4th sample: that beat is dropped.
  assign fire          = full && !abort_pk;
  assign last_beat     = (beat == BEAT_W'(SYM_BEATS - 1));
  assign last_sym      = (sym == nsym_q - 1'b1);
  assign frame_end     = fire && last_beat && last_sym;

  axis_lane_packer #(
    .SAMP_W (SAMP_W),
    .LANES  (LANES)
  ) u_lane_packer (
    .clk    (s_axis_aclk),
    .rst    (s_axis_areset),
    .clr    (start_ok || abort_pk),
    .accept (accept),
    .data   (s_samp_tdata),
    .word   (word),
    .full   (full)
  );

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = PACK;
      PACK:    if (abort_pk || frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      tid_q  <= '0;
      nsym_q <= '0;
      sym    <= '0;
      beat   <= '0;
    end else if (start_ok) begin
      tid_q  <= cfg_tid;
      nsym_q <= cfg_nsym;
      sym    <= '0;
      beat   <= '0;
    end else if (fire) begin
      beat <= last_beat ? '0 : beat + 1'b1;
      if (last_beat) sym <= sym + 1'b1;
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      out_q    <= '0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tvalid_q <= fire;
      done_q   <= frame_end;
      if (fire) out_q <= '{tdata: word, tid: tid_q, tuser: sym, tlast: last_beat};
    end
  end

  assign m_axis_tdata  = out_q.tdata;
  assign m_axis_tid    = out_q.tid;
  assign m_axis_tuser  = out_q.tuser;
  assign m_axis_tlast  = out_q.tlast;
  assign m_axis_tvalid = tvalid_q;
  assign frame_done    = done_q;

endmodule
